onchip_mem_arb2: RTL and testbench

Two-port round-robin arbiter sharing the single-port 51200×32 on-chip RAM between two Avalon-MM requesters, such as a Nios II data master and a DMA. Issues at most one transfer per cycle to the RAM's address/byteenable/chipselect/write/writedata/clken port. Returns read data with fixed 1-cycle latency to the owning requester. Gates new issue during `reset_req`, and blocks out-of-range addresses before they reach the RAM.

---
 rtl/onchip_mem_arb2_pkg.sv | 14 +
 rtl/onchip_mem_arb2_if.sv | 27 ++
 rtl/onchip_mem_arb2_rr_arb2.sv | 47 ++++
 rtl/onchip_mem_arb2.sv | 127 ++++++++++++
 tb/tb_onchip_mem_arb2.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_arb2_pkg.sv
// Shared types and constants for the two-port on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_idx_t;

  localparam int CNT_W         = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_WORDS = 51200;

endpackage

// File: rtl/onchip_mem_arb2_if.sv
// Avalon-MM requester bundle; master drives the request, slave answers it.
interface onchip_mem_arb2_if #(
  parameter int ADDR_W = onchip_mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = onchip_mem_arb_pkg::DEF_DATA_W,
  parameter int BE_W   = DATA_W / 8
);

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_mem_arb2_rr_arb2.sv
// Two-way round-robin grant with a registered last-winner pointer.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] gnt
);

  port_idx_t last_q;
  port_idx_t last_d;

  // Grant decode; on a tie the port that did not win last time goes next.
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (block) begin
      gnt = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == PORT_M1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[1]) begin
      last_d = PORT_M1;
    end else if (gnt[0]) begin
      last_d = PORT_M0;
    end else begin
      last_d = last_q;
    end
  end

  // Last-winner pointer; starts at m1 so m0 takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arb2.sv
// Shares one single-port on-chip RAM between two Avalon-MM requesters with
// round-robin issue, 1-cycle read return, range blocking and grant counters.
module onchip_mem_arb2
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BE_W      = DATA_W / 8,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reset_req,
  onchip_mem_arb2_if.slave     m0,
  onchip_mem_arb2_if.slave     m1,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [BE_W-1:0]      mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic                 mem_clken,
  output logic [DATA_W-1:0]    mem_writedata,
  input  logic [DATA_W-1:0]    mem_readdata,
  output logic                 err_oor,
  input  logic                 err_clear,
  output logic [CNT_W-1:0]     gnt_cnt0,
  output logic [CNT_W-1:0]     gnt_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              any_gnt_s;
  port_idx_t         sel_s;
  logic              sel_write_s;
  logic              sel_oor_s;
  logic [ADDR_W-1:0] sel_address_s;
  logic              rd_valid_s;
  logic [DATA_W-1:0] rd_data_s;

  logic              rd_pend_q, rd_pend_d;
  port_idx_t         rd_owner_q, rd_owner_d;
  logic              rd_oor_q, rd_oor_d;
  logic              err_oor_q, err_oor_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  assign req_s = {m1.read | m1.write, m0.read | m0.write};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_s),
    .block (reset | reset_req),
    .gnt   (gnt_s)
  );

  // Winner mux, RAM issue, and next-state for read return, error and counters.
  always_comb begin
    any_gnt_s     = gnt_s[0] | gnt_s[1];
    sel_s         = gnt_s[1] ? PORT_M1 : PORT_M0;
    sel_address_s = (sel_s == PORT_M1) ? m1.address : m0.address;
    sel_write_s   = (sel_s == PORT_M1) ? m1.write : m0.write;
    sel_oor_s     = (32'(sel_address_s) >= 32'(NUM_WORDS));

    m0.waitrequest = ~gnt_s[0];
    m1.waitrequest = ~gnt_s[1];

    mem_address    = sel_address_s;
    mem_byteenable = (sel_s == PORT_M1) ? m1.byteenable : m0.byteenable;
    mem_writedata  = (sel_s == PORT_M1) ? m1.writedata : m0.writedata;
    mem_chipselect = any_gnt_s & ~sel_oor_s;
    mem_write      = any_gnt_s & ~sel_oor_s & sel_write_s;
    mem_clken      = ~reset_req;

    // A write strobe overrides a simultaneous read, so only pure reads return data.
    rd_pend_d  = any_gnt_s & ~sel_write_s;
    rd_owner_d = sel_s;
    rd_oor_d   = sel_oor_s;

    if (any_gnt_s && sel_oor_s) begin
      err_oor_d = 1'b1;
    end else if (err_clear) begin
      err_oor_d = 1'b0;
    end else begin
      err_oor_d = err_oor_q;
    end

    cnt0_d = (gnt_s[0] && (cnt0_q != CNT_MAX)) ? cnt0_q + CNT_ONE : cnt0_q;
    cnt1_d = (gnt_s[1] && (cnt1_q != CNT_MAX)) ? cnt1_q + CNT_ONE : cnt1_q;
  end

  // Read return steering; a pending read is dropped if reset arrives.
  always_comb begin
    rd_valid_s       = rd_pend_q & ~reset;
    rd_data_s        = rd_oor_q ? {DATA_W{1'b0}} : mem_readdata;
    m0.readdatavalid = rd_valid_s & (rd_owner_q == PORT_M0);
    m1.readdatavalid = rd_valid_s & (rd_owner_q == PORT_M1);
    m0.readdata      = m0.readdatavalid ? rd_data_s : {DATA_W{1'b0}};
    m1.readdata      = m1.readdatavalid ? rd_data_s : {DATA_W{1'b0}};
  end

  // State registers for read return, sticky error and grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= PORT_M0;
      rd_oor_q   <= 1'b0;
      err_oor_q  <= 1'b0;
      cnt0_q     <= {CNT_W{1'b0}};
      cnt1_q     <= {CNT_W{1'b0}};
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      err_oor_q  <= err_oor_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign err_oor  = err_oor_q;
  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_onchip_mem_arb2.sv
// Self-checking bench for onchip_mem_arb2: directed scenarios plus a randomized
// run compared against a transaction-level model with a shadow memory.
module tb_onchip_mem_arb2;

  localparam int NW = 51200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_req = 1'b0;
  logic        err_clear = 1'b0;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic        err_oor;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  int errors = 0;
  int checks = 0;

  onchip_mem_arb2_if m0_if ();
  onchip_mem_arb2_if m1_if ();

  always #5 clk = ~clk;

  onchip_mem_arb2 dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .m0(m0_if), .m1(m1_if),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .err_oor(err_oor), .err_clear(err_clear), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // RAM with registered address and unregistered data output
  logic [31:0] ram [0:NW-1];
  logic [15:0] ram_addr_q = 16'd0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // Reference memory contents as the requesters should see them
  logic [31:0] shadow [int];

  function automatic logic [31:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : 32'h0;
  endfunction

  task automatic shadow_wr(input int a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = shadow_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    shadow[a] = v;
  endtask

  task automatic drv(input int p, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
    end
  endtask

  task automatic idle();
    drv(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(0, 1'b1, 1'b0, 16'h5, 4'hF, 32'h0);
    drv(1, 1'b1, 1'b0, 16'h6, 4'hF, 32'h0);
    tick();
    @(negedge clk);
    checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait0 got=%0b exp=1", m0_if.waitrequest); end
    checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait1 got=%0b exp=1", m1_if.waitrequest); end
    checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin errors++; $display("FAIL rst_rdv got=%b exp=00", {m0_if.readdatavalid, m1_if.readdatavalid}); end
    checks++; if ((m0_if.readdata | m1_if.readdata) !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0", m0_if.readdata, m1_if.readdata); end
    checks++; if ({mem_chipselect, mem_write} !== 2'b00) begin errors++; $display("FAIL rst_cs_we got=%b exp=00", {mem_chipselect, mem_write}); end
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err_oor); end
    checks++; if ({gnt_cnt0, gnt_cnt1} !== 32'h0) begin errors++; $display("FAIL rst_cnt got=%h/%h exp=0", gnt_cnt0, gnt_cnt1); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({m1_if.waitrequest, m0_if.waitrequest} !== 2'b10) begin errors++; $display("FAIL rst_first_tie got=%b exp=10", {m1_if.waitrequest, m0_if.waitrequest}); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (m0_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL rst_first_rdv got=%0b exp=1", m0_if.readdatavalid); end
    tick();
  endtask

  task automatic test_write_read();
    do_reset();
    drv(0, 1'b0, 1'b1, 16'h0010, 4'b0001, 32'h0000_00AA);
    @(negedge clk);
    checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL wr_wait got=%0b exp=0", m0_if.waitrequest); end
    checks++; if ({mem_chipselect, mem_write, mem_byteenable} !== 6'b11_0001) begin errors++; $display("FAIL wr_issue got=%b exp=110001", {mem_chipselect, mem_write, mem_byteenable}); end
    checks++; if (mem_address !== 16'h0010) begin errors++; $display("FAIL wr_addr got=%h exp=0010", mem_address); end
    shadow_wr(16'h0010, 4'b0001, 32'h0000_00AA);
    tick();
    drv(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drv(1, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if ({m1_if.waitrequest, mem_chipselect, mem_write} !== 3'b010) begin errors++; $display("FAIL rd_issue got=%b exp=010", {m1_if.waitrequest, mem_chipselect, mem_write}); end
    tick();
    drv(1, 1'b0, 1'b1, 16'h0011, 4'b1100, 32'h1234_5678);
    @(negedge clk);
    checks++; if (m1_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL wr_rd_rdv got=%0b exp=1", m1_if.readdatavalid); end
    checks++; if (m1_if.readdata !== 32'h0000_00AA) begin errors++; $display("FAIL wr_rd_data got=%h exp=000000aa", m1_if.readdata); end
    checks++; if ({m0_if.readdatavalid, m0_if.readdata} !== 33'h0) begin errors++; $display("FAIL wr_rd_other got=%0b/%h exp=0/0", m0_if.readdatavalid, m0_if.readdata); end
    shadow_wr(16'h0011, 4'b1100, 32'h1234_5678);
    tick();
    drv(1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drv(0, 1'b1, 1'b0, 16'h0011, 4'hF, 32'h0);
    tick();
    idle();
    @(negedge clk);
    checks++; if (m0_if.readdata !== 32'h1234_0000) begin errors++; $display("FAIL be_lanes got=%h exp=12340000", m0_if.readdata); end
    tick();
  endtask

  task automatic test_alternate();
    int prev;
    do_reset();
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      drv(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
      drv(1, 1'b1, 1'b0, 16'h0011, 4'hF, 32'h0);
      @(negedge clk);
      checks++; if ({m1_if.waitrequest, m0_if.waitrequest} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_gnt k=%0d got=%b", k, {m1_if.waitrequest, m0_if.waitrequest}); end
      if (k > 0) begin
        checks++; if ({m1_if.readdatavalid, m0_if.readdatavalid} !== ((prev == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_rdv k=%0d got=%b", k, {m1_if.readdatavalid, m0_if.readdatavalid}); end
        checks++; if ((m0_if.readdata | m1_if.readdata) !== shadow_rd(16 + prev)) begin errors++; $display("FAIL alt_data k=%0d got=%h exp=%h", k, m0_if.readdata | m1_if.readdata, shadow_rd(16 + prev)); end
      end
      prev = k % 2;
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if (m1_if.readdatavalid !== 1'b1) begin errors++; $display("FAIL alt_last_rdv got=%0b exp=1", m1_if.readdatavalid); end
    checks++; if ({gnt_cnt0, gnt_cnt1} !== {16'd4, 16'd4}) begin errors++; $display("FAIL alt_cnt got=%0d/%0d exp=4/4", gnt_cnt0, gnt_cnt1); end
    tick();
  endtask

  task automatic test_oor();
    drv(0, 1'b1, 1'b0, 16'h0011, 4'hF, 32'h0);
    tick();
    drv(0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drv(1, 1'b0, 1'b1, 16'(NW), 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if ({m1_if.waitrequest, mem_chipselect, mem_write} !== 3'b000) begin errors++; $display("FAIL oor_wr_issue got=%b exp=000", {m1_if.waitrequest, mem_chipselect, mem_write}); end
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_err_early got=%0b exp=0", err_oor); end
    tick();
    drv(1, 1'b1, 1'b0, 16'(NW), 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_err_set got=%0b exp=1", err_oor); end
    checks++; if ({m1_if.waitrequest, mem_chipselect} !== 2'b00) begin errors++; $display("FAIL oor_rd_issue got=%b exp=00", {m1_if.waitrequest, mem_chipselect}); end
    tick();
    drv(1, 1'b1, 1'b0, 16'(NW + 1), 4'hF, 32'h0);
    err_clear = 1'b1;
    @(negedge clk);
    checks++; if ({m1_if.readdatavalid, m1_if.readdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL oor_rd_data got=%0b/%h exp=1/0", m1_if.readdatavalid, m1_if.readdata); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_set_wins got=%0b exp=1", err_oor); end
    tick();
    err_clear = 1'b0;
    @(negedge clk);
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_clear got=%0b exp=0", err_oor); end
    tick();
  endtask

  task automatic test_reset_req();
    drv(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL rr_pre_wait got=%0b exp=0", m0_if.waitrequest); end
    tick();
    reset_req = 1'b1;
    drv(1, 1'b1, 1'b0, 16'h0011, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({m0_if.waitrequest, m1_if.waitrequest, mem_clken, mem_chipselect} !== 4'b1100) begin errors++; $display("FAIL rr_block k=%0d got=%b exp=1100", k, {m0_if.waitrequest, m1_if.waitrequest, mem_clken, mem_chipselect}); end
      checks++; if ({m0_if.readdatavalid, m0_if.readdata} !== ((k == 0) ? {1'b1, shadow_rd(16)} : 33'h0)) begin errors++; $display("FAIL rr_rdv k=%0d got=%0b/%h", k, m0_if.readdatavalid, m0_if.readdata); end
      tick();
    end
    reset_req = 1'b0;
    @(negedge clk);
    checks++; if ({m1_if.waitrequest, m0_if.waitrequest, mem_clken} !== 3'b011) begin errors++; $display("FAIL rr_resume got=%b exp=011", {m1_if.waitrequest, m0_if.waitrequest, mem_clken}); end
    tick();
    idle();
    @(negedge clk);
    checks++; if ({m1_if.readdatavalid, m1_if.readdata} !== {1'b1, shadow_rd(17)}) begin errors++; $display("FAIL rr_after got=%0b/%h exp=1/%h", m1_if.readdatavalid, m1_if.readdata, shadow_rd(17)); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    drv(1, 1'b1, 1'b0, 16'h0011, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL rmr_accept got=%0b exp=0", m1_if.waitrequest); end
    tick();
    reset = 1'b1;
    drv(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== 2'b00) begin errors++; $display("FAIL rmr_rdv got=%b exp=00", {m0_if.readdatavalid, m1_if.readdatavalid}); end
    checks++; if ((m0_if.readdata | m1_if.readdata) !== 32'h0) begin errors++; $display("FAIL rmr_rdata got=%h exp=0", m0_if.readdata | m1_if.readdata); end
    checks++; if ({m0_if.waitrequest, m1_if.waitrequest, mem_chipselect, mem_write} !== 4'b1100) begin errors++; $display("FAIL rmr_outs got=%b exp=1100", {m0_if.waitrequest, m1_if.waitrequest, mem_chipselect, mem_write}); end
    tick();
    @(negedge clk);
    checks++; if ({err_oor, gnt_cnt0, gnt_cnt1} !== 33'h0) begin errors++; $display("FAIL rmr_state got=%0b/%h/%h exp=0", err_oor, gnt_cnt0, gnt_cnt1); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({m1_if.waitrequest, m0_if.waitrequest} !== 2'b10) begin errors++; $display("FAIL rmr_tie got=%b exp=10", {m1_if.waitrequest, m0_if.waitrequest}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    drv(0, 1'b1, 1'b0, 16'h0000, 4'hF, 32'h0);
    repeat (65534) tick();
    checks++; if (gnt_cnt0 !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=fffe", gnt_cnt0); end
    tick();
    checks++; if (gnt_cnt0 !== 16'hFFFF) begin errors++; $display("FAIL sat_max got=%h exp=ffff", gnt_cnt0); end
    tick();
    checks++; if ({gnt_cnt0, m0_if.waitrequest} !== {16'hFFFF, 1'b0}) begin errors++; $display("FAIL sat_hold got=%h/%0b exp=ffff/0", gnt_cnt0, m0_if.waitrequest); end
    idle();
    tick();
  endtask

  task automatic test_random();
    logic act [2], p_rd [2], p_wr [2];
    logic [15:0] p_a [2];
    logic [3:0] p_be [2];
    logic [31:0] p_d [2];
    logic exp_v [2];
    logic [31:0] exp_d [2];
    int last_win, w, cnt_m [2], op;
    logic err_m, oor;
    do_reset();
    last_win = 1; err_m = 1'b0;
    for (int p = 0; p < 2; p++) begin act[p] = 1'b0; exp_v[p] = 1'b0; exp_d[p] = 32'h0; cnt_m[p] = 0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 2) != 0) begin
          op = $urandom_range(0, 3);
          act[p] = 1'b1; p_rd[p] = (op != 1); p_wr[p] = (op == 1 || op == 2);
          p_a[p] = ($urandom_range(0, 15) == 0) ? 16'(NW + $urandom_range(0, 100)) : 16'($urandom_range(0, 31));
          p_be[p] = 4'($urandom_range(0, 15)); p_d[p] = $urandom;
        end
        drv(p, act[p] & p_rd[p], act[p] & p_wr[p], p_a[p], p_be[p], p_d[p]);
      end
      reset_req = ($urandom_range(0, 7) == 0);
      err_clear = ($urandom_range(0, 9) == 0);
      w = -1;
      if (!reset_req) begin
        if (act[0] && act[1]) w = (last_win == 1) ? 0 : 1;
        else if (act[0]) w = 0;
        else if (act[1]) w = 1;
      end
      oor = (w >= 0) && (int'(p_a[w]) >= NW);
      @(negedge clk);
      checks++; if ({m1_if.waitrequest, m0_if.waitrequest} !== {w != 1, w != 0}) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp_win=%0d", cyc, {m1_if.waitrequest, m0_if.waitrequest}, w); end
      checks++; if ({m0_if.readdatavalid, m0_if.readdata, m1_if.readdatavalid, m1_if.readdata} !== {exp_v[0], exp_v[0] ? exp_d[0] : 32'h0, exp_v[1], exp_v[1] ? exp_d[1] : 32'h0}) begin
        errors++; $display("FAIL rnd_read c=%0d got=%0b/%h %0b/%h exp=%0b/%h %0b/%h", cyc, m0_if.readdatavalid, m0_if.readdata, m1_if.readdatavalid, m1_if.readdata, exp_v[0], exp_d[0], exp_v[1], exp_d[1]);
      end
      checks++; if ({mem_chipselect, err_oor, mem_clken} !== {(w >= 0) && !oor, err_m, !reset_req}) begin errors++; $display("FAIL rnd_mem c=%0d got=%b exp=%b", cyc, {mem_chipselect, err_oor, mem_clken}, {(w >= 0) && !oor, err_m, !reset_req}); end
      exp_v[0] = 1'b0; exp_v[1] = 1'b0;
      if (w >= 0) begin
        if (p_wr[w]) begin
          if (!oor) shadow_wr(int'(p_a[w]), p_be[w], p_d[w]);
        end else begin
          exp_v[w] = 1'b1; exp_d[w] = oor ? 32'h0 : shadow_rd(int'(p_a[w]));
        end
        cnt_m[w] = cnt_m[w] + 1; last_win = w; act[w] = 1'b0;
      end
      err_m = oor ? 1'b1 : (err_clear ? 1'b0 : err_m);
      tick();
    end
    idle(); reset_req = 1'b0; err_clear = 1'b0;
    @(negedge clk);
    checks++; if ({m0_if.readdatavalid, m1_if.readdatavalid} !== {exp_v[0], exp_v[1]}) begin errors++; $display("FAIL rnd_tail got=%b exp=%b", {m0_if.readdatavalid, m1_if.readdatavalid}, {exp_v[0], exp_v[1]}); end
    checks++; if ({gnt_cnt0, gnt_cnt1} !== {16'(cnt_m[0]), 16'(cnt_m[1])}) begin errors++; $display("FAIL rnd_cnt got=%0d/%0d exp=%0d/%0d", gnt_cnt0, gnt_cnt1, cnt_m[0], cnt_m[1]); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ram[i] = 32'h0;
    idle();
    test_reset();
    test_write_read();
    test_alternate();
    test_oor();
    test_reset_req();
    test_reset_mid_read();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
